sorted_insert_writer: RTL and testbench

//  Writer side of the sorted-RAM binary search: builds the ascending-ordered array the search reads.

---
 rtl/sorted_insert_writer_if.sv | 36 +++
 rtl/sorted_insert_writer.sv | 119 +++++++++++
 tb/tb_sorted_insert_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_insert_writer_if.sv
// Bus bundle for sorted_insert_writer: insert request, RAM port and status.
// WRITER_CLEAR_EN adds the clear request line.
interface sorted_insert_writer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              full;
`ifdef WRITER_CLEAR_EN
    logic              clear;
`endif

    modport slave (
`ifdef WRITER_CLEAR_EN
        input  clear,
`endif
        input  start, data_in, ram_rdata,
        output ram_addr, ram_wdata, ram_we, count, busy, done, full
    );

    modport master (
`ifdef WRITER_CLEAR_EN
        output clear,
`endif
        output start, data_in, ram_rdata,
        input  ram_addr, ram_wdata, ram_we, count, busy, done, full
    );
endinterface

// File: rtl/sorted_insert_writer.sv
// In-place insertion sort writer: each accepted start inserts one byte into an ascending RAM array.
// Optional feature macro WRITER_CLEAR_EN: clear input empties the array (count only) from IDLE.
module sorted_insert_writer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sorted_insert_writer_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_INS, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full;
    logic              clear_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;

    assign full = (count_q == CNT_W'(DEPTH));

`ifdef WRITER_CLEAR_EN
    assign clear_req = bus.clear;
`else
    assign clear_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        data_d    = data_q;
        count_d   = count_q;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    count_d = '0;
                end else if (bus.start && !full) begin
                    data_d = bus.data_in;
                    if (count_q == '0) begin
                        pos_d   = '0;
                        state_d = S_INS;
                    end else begin
                        idx_d   = ADDR_W'(count_q - 1'b1);
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                ram_addr = idx_q;
                state_d  = S_CMP;
            end
            S_CMP: begin
                // Strictly greater shifts up, so equal keys keep arrival order.
                if (bus.ram_rdata > data_q) begin
                    ram_addr  = idx_q + 1'b1;
                    ram_wdata = bus.ram_rdata;
                    ram_we    = 1'b1;
                    if (idx_q == '0) begin
                        pos_d   = '0;
                        state_d = S_INS;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_RD;
                    end
                end else begin
                    pos_d   = idx_q + 1'b1;
                    state_d = S_INS;
                end
            end
            S_INS: begin
                ram_addr  = pos_q;
                ram_wdata = data_q;
                ram_we    = 1'b1;
                count_d   = count_q + 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (!bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_we    = ram_we;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.busy      = (state_q == S_RD) || (state_q == S_CMP) || (state_q == S_INS);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_sorted_insert_writer.sv
// Scoreboard bench for sorted_insert_writer: sorted-queue reference model, RAM model, decoupled monitor.
module tb_sorted_insert_writer;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    typedef struct packed {
        logic [7:0]       cnt;
        logic [7:0]       lat;
        logic             chk_lat;
        logic [31:0][7:0] arr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sorted_insert_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sorted_insert_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        else            bus.ram_rdata     <= mem[bus.ram_addr];
    end

    logic clr_now;
`ifdef WRITER_CLEAR_EN
    assign clr_now = bus.clear;
`else
    assign clr_now = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model_q [$];
    exp_t       exp_q [$];

    function automatic void check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on each rising done and checks RAM, count, latency, write rules.
    int         cyc = 0;
    int         acc_cyc = 0;
    logic       prev_done = 1'b0;
    logic [31:0] wr_mask = '0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            prev_done = 1'b0;
            wr_mask   = '0;
        end else begin
            if (bus.ram_we) begin
                check("we_only_when_busy", int'(bus.busy), 1);
                check("no_double_write", int'(wr_mask[bus.ram_addr]), 0);
                wr_mask[bus.ram_addr] = 1'b1;
            end
            if (bus.done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("count", int'(bus.count), int'(e.cnt));
                    for (int i = 0; i < int'(e.cnt); i++)
                        check($sformatf("ram[%0d]", i), int'(mem[i]), int'(e.arr[i]));
                    if (e.chk_lat) check("latency", cyc - acc_cyc, int'(e.lat));
                end
            end
            if (bus.start && !bus.busy && !bus.done && !bus.full && !clr_now) begin
                acc_cyc = cyc;
                wr_mask = '0;
            end
            prev_done = bus.done;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_we", int'(bus.ram_we), 0);
        check("rst_full", int'(bus.full), 0);
        reset_n = 1'b1;
        model_q.delete();
        exp_q.delete();
    endtask

    task automatic insert(input logic [7:0] v);
        exp_t e;
        int   pos;
        int   t;
        pos = model_q.size();
        for (int j = 0; j < model_q.size(); j++)
            if (model_q[j] > v) begin pos = j; break; end
        model_q.insert(pos, v);
        e = '0;
        e.cnt     = 8'(model_q.size());
        e.lat     = 8'(2 * (model_q.size() - 1) + 2);
        e.chk_lat = (pos == 0);
        for (int j = 0; j < model_q.size(); j++) e.arr[j] = model_q[j];
        exp_q.push_back(e);

        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = v;
        @(posedge clk); #1;
        bus.data_in = 8'($urandom);
        t = 0;
        while (!bus.done && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout value=%0d actual=timeout required=done", v);
        end
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
`ifdef WRITER_CLEAR_EN
        bus.clear   = 1'b0;
`endif
        do_reset();
        insert(8'd20);

        do_reset();
        insert(8'd5);
        insert(8'd10);
        insert(8'd30);
        insert(8'd12);
        insert(8'd1);
        insert(8'd10);

        while (model_q.size() < DEPTH) begin
            if ($urandom_range(0, 1) == 1) insert(8'($urandom_range(0, 255)));
            else                           insert(8'($urandom_range(0, 15) * 16));
        end
        @(posedge clk); #1;
        check("full_flag", int'(bus.full), 1);
        check("full_count", int'(bus.count), DEPTH);
        bus.start = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("full_no_we", int'(bus.ram_we), 0);
            check("full_no_done", int'(bus.done), 0);
            check("full_no_busy", int'(bus.busy), 0);
        end
        bus.start = 1'b0;
        check("full_count_kept", int'(bus.count), DEPTH);

        do_reset();
        insert(8'd5);
        insert(8'd10);
        insert(8'd30);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = 8'd12;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("cmp_busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_count", int'(bus.count), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        reset_n = 1'b1;
        model_q.delete();
        exp_q.delete();

`ifdef WRITER_CLEAR_EN
        insert(8'd7);
        insert(8'd3);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.clear   = 1'b1;
        bus.data_in = 8'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        check("clear_count", int'(bus.count), 0);
        check("clear_busy", int'(bus.busy), 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("clear_no_done", int'(bus.done), 0);
        end
        model_q.delete();
        insert(8'd4);
`endif
        insert(8'd99);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
